// File: rtl/riscv_pkg.sv
// riscv_pkg: opcode/funct3 constants, bubble encoding and IF/ID register layout
package riscv_pkg;
  localparam int IF_ID_XLEN = 32;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [IF_ID_XLEN-1:0] pc;
    logic [31:0]           instr;
    logic                  valid;
  } if_id_t;
endpackage

// File: rtl/id_fetch_ctrl_if.sv
// id_fetch_ctrl_if: IF/RF/EX/MEM-facing signal bundle of the decode-side fetch controller
interface id_fetch_ctrl_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] IF_pc_i;
  logic [31:0]     IMEM_instr_i;
  logic [XLEN-1:0] RF_rs1_data_i;
  logic [XLEN-1:0] RF_rs2_data_i;
  logic [4:0]      RF_rs1_o;
  logic [4:0]      RF_rs2_o;
  logic            EX_reg_write_i;
  logic            EX_mem_read_i;
  logic [4:0]      EX_rd_i;
  logic            MEM_reg_write_i;
  logic            MEM_mem_read_i;
  logic [4:0]      MEM_rd_i;
  logic [XLEN-1:0] MEM_result_i;
  logic            ID_branch_en_o;
  logic [XLEN-1:0] ID_Branch_target_o;
  logic            ID_stall_o;
  logic [XLEN-1:0] ID_pc_o;
  logic [31:0]     ID_instr_o;
  logic            ID_valid_o;
  logic            ID_bubble_o;
  logic [31:0]     stall_cnt_o;
  logic [31:0]     flush_cnt_o;
  modport slave (
    input  IF_pc_i, IMEM_instr_i, RF_rs1_data_i, RF_rs2_data_i,
           EX_reg_write_i, EX_mem_read_i, EX_rd_i,
           MEM_reg_write_i, MEM_mem_read_i, MEM_rd_i, MEM_result_i,
    output RF_rs1_o, RF_rs2_o, ID_branch_en_o, ID_Branch_target_o, ID_stall_o,
           ID_pc_o, ID_instr_o, ID_valid_o, ID_bubble_o, stall_cnt_o, flush_cnt_o
  );
  modport master (
    output IF_pc_i, IMEM_instr_i, RF_rs1_data_i, RF_rs2_data_i,
           EX_reg_write_i, EX_mem_read_i, EX_rd_i,
           MEM_reg_write_i, MEM_mem_read_i, MEM_rd_i, MEM_result_i,
    input  RF_rs1_o, RF_rs2_o, ID_branch_en_o, ID_Branch_target_o, ID_stall_o,
           ID_pc_o, ID_instr_o, ID_valid_o, ID_bubble_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/branch_resolve.sv
// branch_resolve: control-flow decode, branch compare and redirect target adder
module branch_resolve import riscv_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            is_branch,
  output logic            is_jal,
  output logic            is_jalr,
  output logic            taken,
  output logic [XLEN-1:0] target
);
  logic [2:0]      f3;
  logic            eq, lt, ltu, cond;
  logic [XLEN-1:0] imm_b, imm_j, imm_i;
  assign f3        = instr[14:12];
  assign is_branch = instr[6:0] == OP_BRANCH;
  assign is_jal    = instr[6:0] == OP_JAL;
  assign is_jalr   = instr[6:0] == OP_JALR;
  assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign eq  = rs1_val == rs2_val;
  assign lt  = $signed(rs1_val) < $signed(rs2_val);
  assign ltu = rs1_val < rs2_val;
  // funct3 010/011 are not branches and never redirect
  assign cond = (f3 == F3_BEQ)  ? eq  :
                (f3 == F3_BNE)  ? !eq :
                (f3 == F3_BLT)  ? lt  :
                (f3 == F3_BGE)  ? !lt :
                (f3 == F3_BLTU) ? ltu :
                (f3 == F3_BGEU) ? !ltu : 1'b0;
  assign taken  = is_jal || is_jalr || (is_branch && cond);
  assign target = is_jalr ? (rs1_val + imm_i) & ~XLEN'(1) : pc + (is_jal ? imm_j : imm_b);
endmodule

// File: rtl/id_fetch_ctrl.sv
// id_fetch_ctrl: IF/ID register, ID-stage branch resolution, RAW stall and flush control
module id_fetch_ctrl import riscv_pkg::*; #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input logic           clk_i,
  input logic           rst_i,
  id_fetch_ctrl_if.slave bus
);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t          state, state_nxt;
  if_id_t          r;
  logic [6:0]      op;
  logic [4:0]      rs1, rs2;
  logic [XLEN-1:0] rs1_val, rs2_val, target;
  logic            valid, is_branch, is_jal, is_jalr, taken;
  logic            use1, use2, ex_hit, mem_hit, hazard, branch_en, flush;
  logic [31:0]     stall_cnt, flush_cnt;
  assign op    = r.instr[6:0];
  assign rs1   = r.instr[19:15];
  assign rs2   = r.instr[24:20];
  assign valid = r.valid && state == RUN;
  // only forward ALU results from MEM; a load's data is not available yet
  assign rs1_val = (rs1 == '0) ? '0 :
                   (bus.MEM_reg_write_i && !bus.MEM_mem_read_i && bus.MEM_rd_i == rs1) ? bus.MEM_result_i :
                   bus.RF_rs1_data_i;
  assign rs2_val = (rs2 == '0) ? '0 :
                   (bus.MEM_reg_write_i && !bus.MEM_mem_read_i && bus.MEM_rd_i == rs2) ? bus.MEM_result_i :
                   bus.RF_rs2_data_i;
  branch_resolve #(.XLEN(XLEN)) u_br (
    .pc(r.pc), .instr(r.instr), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr), .taken(taken), .target(target)
  );
  assign use1    = !(is_jal || op == OP_LUI || op == OP_AUIPC);
  assign use2    = use1 && !is_jalr;
  assign ex_hit  = bus.EX_rd_i != '0 && ((use1 && bus.EX_rd_i == rs1) || (use2 && bus.EX_rd_i == rs2));
  assign mem_hit = bus.MEM_rd_i != '0 && ((use1 && bus.MEM_rd_i == rs1) || (use2 && bus.MEM_rd_i == rs2));
  // branches compare in ID, so they also wait on ALU results in EX and loads in MEM
  assign hazard = valid && ((bus.EX_mem_read_i && ex_hit) ||
                  ((is_branch || is_jalr) && ((bus.EX_reg_write_i && ex_hit) || (bus.MEM_mem_read_i && mem_hit))));
  assign branch_en = valid && !hazard && taken;
  // next state: one FLUSH cycle squashes the wrong-path fetch after a redirect
  always_comb begin
    state_nxt = RUN;
    flush     = 1'b0;
    if (state == RUN && branch_en) begin
      state_nxt = FLUSH;
      flush     = 1'b1;
    end
  end
  // state register
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) state <= RUN;
    else state <= state_nxt;
  // IF/ID register and performance counters
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      r         <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (flush) r <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
      else if (!hazard) r <= '{pc: bus.IF_pc_i, instr: bus.IMEM_instr_i, valid: 1'b1};
      stall_cnt <= stall_cnt + 32'(hazard);
      flush_cnt <= flush_cnt + 32'(branch_en);
    end
  assign bus.RF_rs1_o           = rs1;
  assign bus.RF_rs2_o           = rs2;
  assign bus.ID_branch_en_o     = branch_en;
  assign bus.ID_Branch_target_o = branch_en ? target : '0;
  assign bus.ID_stall_o         = hazard;
  assign bus.ID_pc_o            = r.pc;
  assign bus.ID_instr_o         = r.instr;
  assign bus.ID_valid_o         = valid;
  assign bus.ID_bubble_o        = hazard || !valid;
  assign bus.stall_cnt_o        = stall_cnt;
  assign bus.flush_cnt_o        = flush_cnt;
endmodule
